// File: rtl/vram_arbiter_pkg.sv
// Shared constants for the VRAM arbiter: bus width default and FSM encodings.
package vram_arbiter_pkg;

    localparam int VRAM_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_READ  = 2'd1,
        ARB_TURN  = 2'd2,
        ARB_WRITE = 2'd3
    } arb_state_e;

endpackage

// File: rtl/vram_wr_fifo_m.sv
// Synchronous CPU write FIFO. Full/empty derive from a separate count so the
// pointers can simply wrap modulo the (power-of-two) depth.
module vram_wr_fifo_m #(
    parameter  int WIDTH = 20,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic [CNT_W-1:0] o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    // Guard against overflow/underflow so a misbehaving requester cannot corrupt the count.
    assign w_push  = i_push && (r_count != CNT_W'(DEPTH));
    assign w_pop   = i_pop && (r_count != '0);
    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Storage array; no reset needed since the count masks stale entries.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vram_arbiter_m.sv
// VRAM bus owner: GPU pixel-fetch reads win by default, queued CPU writes drain
// in idle cycles or in a forced slot once the starve counter saturates.
//
//   state | meaning
//   IDLE  | bus quiet, nothing to do
//   READ  | GPU read issued this cycle (grant), data registered next cycle
//   TURN  | bus-turnaround idle cycle between a READ and a WRITE
//   WRITE | FIFO head written to VRAM, popped at end of cycle
//
// The state is decided combinationally each cycle from the GPU request, FIFO
// occupancy, starve flag and the previous cycle's state (r_state), so a GPU
// request is granted in the same cycle it is presented.
module vram_arbiter_m
    import vram_arbiter_pkg::*;
#(
    parameter int ADDR_W     = VRAM_ADDR_WIDTH,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_cpu_wr_valid,
    output logic              o_cpu_wr_ready,
    input  logic [ADDR_W-1:0] i_cpu_wr_addr,
    input  logic [DATA_W-1:0] i_cpu_wr_data,
    input  logic              i_gpu_rd_req,
    input  logic [ADDR_W-1:0] i_gpu_rd_addr,
    output logic              o_gpu_rd_grant,
    output logic              o_gpu_rd_valid,
    output logic [DATA_W-1:0] o_gpu_rd_data,
    output logic [ADDR_W-1:0] o_vram_addr,
    output logic [DATA_W-1:0] o_vram_wdata,
    input  logic [DATA_W-1:0] i_vram_rdata,
    output logic              o_vram_cs,
    output logic              o_vram_oe,
    output logic              o_vram_we
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int SW    = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX - 1);

    arb_state_e                 r_state;
    arb_state_e                 w_state;
    logic [SW-1:0]              r_starve_cnt;
    logic                       w_starve;
    logic                       r_rd_valid;
    logic [DATA_W-1:0]          r_rd_data;
    logic [CNT_W-1:0]           w_fifo_count;
    logic                       w_fifo_empty;
    logic                       w_fifo_push;
    logic                       w_fifo_pop;
    logic [ADDR_W+DATA_W-1:0]   w_fifo_head;

    assign w_fifo_empty   = (w_fifo_count == '0);
    assign o_cpu_wr_ready = (w_fifo_count != CNT_W'(FIFO_DEPTH));
    assign w_fifo_push    = i_cpu_wr_valid && o_cpu_wr_ready;
    assign w_starve       = (r_starve_cnt >= STARVE_LIM) && !w_fifo_empty;
    assign o_gpu_rd_valid = r_rd_valid;
    assign o_gpu_rd_data  = r_rd_data;

    vram_wr_fifo_m #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_wr_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (w_fifo_push),
        .i_wdata ({i_cpu_wr_addr, i_cpu_wr_data}),
        .i_pop   (w_fifo_pop),
        .o_rdata (w_fifo_head),
        .o_count (w_fifo_count)
    );

    // Remember this cycle's decision so the next cycle knows whether a turnaround is due.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Arbitration decision and bus drive; reset forces IDLE so the bus is quiet immediately.
    always_comb begin
        w_state        = ARB_IDLE;
        o_gpu_rd_grant = 1'b0;
        o_vram_cs      = 1'b0;
        o_vram_oe      = 1'b0;
        o_vram_we      = 1'b0;
        o_vram_addr    = '0;
        o_vram_wdata   = '0;
        w_fifo_pop     = 1'b0;

        if (!i_rst_n) begin
            w_state = ARB_IDLE;
        end else if (r_state == ARB_TURN) begin
            w_state = ARB_WRITE;
        end else if (i_gpu_rd_req && !w_starve) begin
            w_state = ARB_READ;
        end else if (w_starve || !w_fifo_empty) begin
            w_state = (r_state == ARB_READ) ? ARB_TURN : ARB_WRITE;
        end

        case (w_state)
            ARB_READ: begin
                o_gpu_rd_grant = 1'b1;
                o_vram_cs      = 1'b1;
                o_vram_oe      = 1'b1;
                o_vram_addr    = i_gpu_rd_addr;
            end
            ARB_WRITE: begin
                o_vram_cs    = 1'b1;
                o_vram_we    = 1'b1;
                o_vram_addr  = w_fifo_head[ADDR_W+DATA_W-1:DATA_W];
                o_vram_wdata = w_fifo_head[DATA_W-1:0];
                w_fifo_pop   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Starvation counter: counts READs won while writes wait; saturates, never wraps.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_starve_cnt <= '0;
        end else if (w_fifo_empty || (w_state == ARB_WRITE)) begin
            r_starve_cnt <= '0;
        end else if ((w_state == ARB_READ) && (r_starve_cnt != STARVE_LIM)) begin
            r_starve_cnt <= r_starve_cnt + SW'(1);
        end
    end

    // Read return register: data and valid one cycle after the grant.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_valid <= (w_state == ARB_READ);
            if (w_state == ARB_READ) begin
                r_rd_data <= i_vram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_vram_arbiter_m.sv
// Scoreboard bench for vram_arbiter_m: a VRAM model behind the bus, a GPU
// stream driver, directed CPU pushes, and a negedge monitor that pops
// expected writes/reads as the DUT presents them.
module tb_vram_arbiter_m;

    logic        clk;
    logic        rst_n;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [11:0] cpu_wr_addr;
    logic [7:0]  cpu_wr_data;
    logic        gpu_rd_req;
    logic [11:0] gpu_rd_addr;
    logic        gpu_rd_grant;
    logic        gpu_rd_valid;
    logic [7:0]  gpu_rd_data;
    logic [11:0] vram_addr;
    logic [7:0]  vram_wdata;
    logic [7:0]  vram_rdata;
    logic        vram_cs;
    logic        vram_oe;
    logic        vram_we;

    int n_checks = 0;
    int n_pass   = 0;
    int n_writes = 0;
    int n_grants = 0;
    int drv_seen = 0;

    logic [19:0] wr_q[$];
    logic [7:0]  rd_q[$];
    logic [1:0]  trace_q[$];
    logic        trace_on = 1'b0;
    logic        gpu_run  = 1'b0;
    logic [11:0] gpu_base = '0;
    logic        prev_grant = 1'b0;
    logic [1:0]  code;
    logic [7:0]  vmem [4096];

    vram_arbiter_m dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cpu_wr_valid (cpu_wr_valid),
        .o_cpu_wr_ready (cpu_wr_ready),
        .i_cpu_wr_addr  (cpu_wr_addr),
        .i_cpu_wr_data  (cpu_wr_data),
        .i_gpu_rd_req   (gpu_rd_req),
        .i_gpu_rd_addr  (gpu_rd_addr),
        .o_gpu_rd_grant (gpu_rd_grant),
        .o_gpu_rd_valid (gpu_rd_valid),
        .o_gpu_rd_data  (gpu_rd_data),
        .o_vram_addr    (vram_addr),
        .o_vram_wdata   (vram_wdata),
        .i_vram_rdata   (vram_rdata),
        .o_vram_cs      (vram_cs),
        .o_vram_oe      (vram_oe),
        .o_vram_we      (vram_we)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // VRAM model: contents start as addr[7:0]+0x1A, synchronous write, async read.
    initial begin
        for (int i = 0; i < 4096; i++) vmem[i] = 8'(i) + 8'h1A;
        forever begin
            @(posedge clk);
            if (vram_cs && vram_we) vmem[vram_addr] = vram_wdata;
        end
    end
    assign vram_rdata = (vram_cs && vram_oe) ? vmem[vram_addr] : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    // GPU fetch engine: holds req/addr until granted, then advances the address.
    always @(posedge clk) begin
        #1;
        if (gpu_run && gpu_rd_req && (n_grants != drv_seen)) gpu_rd_addr = gpu_rd_addr + 12'd1;
        else if (gpu_run && !gpu_rd_req) gpu_rd_addr = gpu_base;
        drv_seen   = n_grants;
        gpu_rd_req = gpu_run;
    end

    // Monitor: bus legality, write scoreboard, read-return scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_grant = 1'b0;
        end else begin
            if (vram_cs && vram_we && !vram_oe) code = 2'd2;
            else if (vram_cs && vram_oe && !vram_we) code = 2'd1;
            else if (!vram_cs && !vram_oe && !vram_we) code = 2'd0;
            else code = 2'd3;
            if (trace_on) trace_q.push_back(code);
            if (vram_we) begin
                n_writes++;
                chk("wr_bus_legal", {30'd0, code}, 32'd2);
                if (wr_q.size() > 0) chk("wr_addr_data", {vram_addr, vram_wdata}, wr_q.pop_front());
                else chk("wr_expected_present", wr_q.size(), 1);
            end
            if (gpu_rd_valid || prev_grant) chk("rd_valid_timing", gpu_rd_valid, prev_grant);
            if (gpu_rd_valid) begin
                if (rd_q.size() > 0) chk("rd_data", gpu_rd_data, rd_q.pop_front());
                else chk("rd_expected_present", rd_q.size(), 1);
            end
            if (gpu_rd_grant) begin
                chk("grant_bus", {gpu_rd_req, code}, 3'b101);
                rd_q.push_back(gpu_rd_addr[7:0] + 8'h1A);
                n_grants++;
            end
            prev_grant = gpu_rd_grant;
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          k;
        int          g0;
        int          w0;
        logic [23:0] tv;

        rst_n        = 1'b0;
        cpu_wr_valid = 1'b0;
        cpu_wr_addr  = '0;
        cpu_wr_data  = '0;
        gpu_rd_req   = 1'b0;
        gpu_rd_addr  = '0;

        // Reset state
        #3;
        chk("reset_ready", cpu_wr_ready, 1);
        chk("reset_bus", {vram_cs, vram_oe, vram_we}, 0);
        chk("reset_grant_valid", {gpu_rd_grant, gpu_rd_valid}, 0);
        chk("reset_rd_data", gpu_rd_data, 0);
        smp(); smp();
        rst_n = 1'b1;
        smp();

        // 1: CPU-only write, no turnaround
        chk("t1_ready", cpu_wr_ready, 1);
        cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h123; cpu_wr_data = 8'hAB;
        wr_q.push_back({12'h123, 8'hAB});
        smp();
        cpu_wr_valid = 1'b0;
        chk("t1_write_cycle", {vram_cs, vram_oe, vram_we}, 3'b101);
        smp();
        chk("t1_idle_after", vram_cs, 0);
        chk("t1_ready_after", cpu_wr_ready, 1);

        // 2: GPU-only read stream from 0x040
        gpu_base = 12'h040; gpu_run = 1'b1; g0 = n_grants;
        smp();
        chk("t2_grant_same_cycle", gpu_rd_grant, 1);
        chk("t2_vram_addr", vram_addr, 12'h040);
        smp();
        chk("t2_rd_valid", gpu_rd_valid, 1);
        chk("t2_rd_data", gpu_rd_data, 8'h5A);
        for (int i = 0; i < 8; i++) smp();
        gpu_run = 1'b0;
        chk("t2_grants_in_10", n_grants - g0, 10);
        smp(); smp();

        // 3: starvation slot under continuous GPU load
        gpu_base = 12'h100; gpu_run = 1'b1;
        smp(); smp(); smp();
        chk("t3_read_at_push", gpu_rd_grant, 1);
        cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h200; cpu_wr_data = 8'h11;
        wr_q.push_back({12'h200, 8'h11});
        trace_on = 1'b1;
        smp();
        cpu_wr_valid = 1'b0;
        k = 0;
        while (trace_q.size() < 12 && k < 30) begin smp(); k++; end
        trace_on = 1'b0;
        tv = '0;
        for (int i = 0; i < 12 && i < trace_q.size(); i++) tv = {tv[21:0], trace_q[i]};
        chk("t3_starve_trace", tv, 24'h555495);
        trace_q.delete();
        gpu_run = 1'b0;
        smp(); smp(); smp();

        // 4: FIFO full under continuous GPU load, 5 pushes
        gpu_base = 12'h140; gpu_run = 1'b1;
        smp(); smp(); smp();
        w0 = n_writes;
        for (int i = 0; i < 5; i++) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 12'h300 + 12'(i);
            cpu_wr_data  = 8'hC0 + 8'(i);
            if (i == 4) chk("t4_full_after_4", cpu_wr_ready, 0);
            k = 0;
            while (!cpu_wr_ready && k < 40) begin smp(); k++; end
            if (i < 4) chk("t4_no_wait", k, 0);
            else begin
                chk("t4_5th_wait_bound", k < 40, 1);
                chk("t4_5th_after_pop", n_writes - w0, 1);
            end
            wr_q.push_back({cpu_wr_addr, cpu_wr_data});
            smp();
        end
        cpu_wr_valid = 1'b0;
        k = 0;
        while (wr_q.size() > 0 && k < 300) begin smp(); k++; end
        chk("t4_drained_in_order", wr_q.size(), 0);
        gpu_run = 1'b0;
        smp(); smp(); smp();

        // 5: GPU request drops with a write queued -> one TURN then WRITE
        gpu_base = 12'h180; gpu_run = 1'b1;
        smp(); smp();
        cpu_wr_valid = 1'b1; cpu_wr_addr = 12'h3A0; cpu_wr_data = 8'h77;
        wr_q.push_back({12'h3A0, 8'h77});
        smp();
        cpu_wr_valid = 1'b0;
        smp();
        gpu_run = 1'b0; trace_on = 1'b1;
        smp(); smp(); smp();
        trace_on = 1'b0;
        tv = '0;
        for (int i = 0; i < 3 && i < trace_q.size(); i++) tv = {tv[21:0], trace_q[i]};
        chk("t5_turn_then_write", tv, 24'h000008);
        trace_q.delete();
        smp();

        // 6: async reset during WRITE with 3 entries queued
        gpu_base = 12'h1C0; gpu_run = 1'b1;
        smp(); smp();
        for (int i = 0; i < 3; i++) begin
            cpu_wr_valid = 1'b1;
            cpu_wr_addr  = 12'h3B0 + 12'(i);
            cpu_wr_data  = 8'hE0 + 8'(i);
            chk("t6_ready_for_push", cpu_wr_ready, 1);
            wr_q.push_back({cpu_wr_addr, cpu_wr_data});
            smp();
        end
        cpu_wr_valid = 1'b0; gpu_run = 1'b0;
        k = 0;
        while (!vram_we && k < 20) begin smp(); k++; end
        chk("t6_write_seen", vram_we, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_bus_low_in_reset", {vram_cs, vram_oe, vram_we}, 0);
        chk("t6_ready_in_reset", cpu_wr_ready, 1);
        chk("t6_valid_in_reset", gpu_rd_valid, 0);
        wr_q.delete();
        rd_q.delete();
        w0 = n_writes;
        smp(); smp();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) smp();
        chk("t6_no_writes_after_reset", n_writes - w0, 0);
        chk("t6_ready_after_reset", cpu_wr_ready, 1);

        chk("sb_wr_empty", wr_q.size(), 0);
        chk("sb_rd_empty", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
